// File: rtl/e_gpu_pkg.sv
// Shared definitions for the GPU configuration block: register word indices,
// the launch FSM state type and STATUS field layout.
package e_gpu_pkg;

  // Register word indices decoded from addr[4:2]
  localparam logic [2:0] REG_ENABLE    = 3'd0;
  localparam logic [2:0] REG_START     = 3'd1;
  localparam logic [2:0] REG_IRQ_CLEAR = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_KERNEL_PC = 3'd4;
  localparam logic [2:0] REG_CYCLE_CNT = 3'd5;

  typedef enum logic [1:0] {
    CONF_IDLE    = 2'd0,
    CONF_RUNNING = 2'd1,
    CONF_DONE    = 2'd2
  } conf_state_e;

  localparam int unsigned STATUS_STATE_LSB = 0;
  localparam int unsigned STATUS_EN_BIT    = 2;
  localparam int unsigned STATUS_IRQ_BIT   = 3;

  function automatic logic [31:0] pack_status(input conf_state_e st, input logic en,
                                              input logic irq);
    logic [31:0] s;
    s = '0;
    s[STATUS_STATE_LSB +: 2] = st;
    s[STATUS_EN_BIT]         = en;
    s[STATUS_IRQ_BIT]        = irq;
    return s;
  endfunction

endpackage

// File: rtl/obi_if.sv
// OBI request and response bundles used by the host port of the GPU
// configuration registers.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport master (output req, we, be, addr, wdata, input gnt);
  modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (input rvalid, rdata);
  modport slave  (output rvalid, rdata);
endinterface

// File: rtl/gpu_conf_obi_slave.sv
// OBI slave front end: zero-wait grant, address decode into write strobes and a
// registered single-cycle response. CYCLE_CNT is mapped only with
// GPU_CONF_REGS_CYCLE_CNT_EN.
module gpu_conf_obi_slave
  import e_gpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  obi_req_if.slave    req_if,
  obi_rsp_if.slave    rsp_if,
  output logic        enable_we_o,
  output logic        start_we_o,
  output logic        irq_clr_we_o,
  output logic [3:0]  kpc_be_o,
  output logic [31:0] wdata_o,
  input  logic        enable_i,
  input  logic [31:0] status_i,
  input  logic [31:0] kernel_pc_i
`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
  ,
  input  logic [31:0] cycle_cnt_i
`endif
);

  logic        in_range;
  logic [2:0]  idx;
  logic        wr_hit;
  logic        rd_hit;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  // Only word-aligned offsets inside the 32-byte window are mapped
  assign in_range = ({req_if.addr[31:5], req_if.addr[1:0]} == '0);
  assign idx      = req_if.addr[4:2];
  assign wr_hit   = req_if.req & req_if.we & in_range;
  assign rd_hit   = req_if.req & ~req_if.we & in_range;

  assign req_if.gnt = req_if.req & rst_ni;

  assign enable_we_o  = wr_hit & req_if.be[0] & (idx == REG_ENABLE);
  assign start_we_o   = wr_hit & req_if.be[0] & (idx == REG_START);
  assign irq_clr_we_o = wr_hit & req_if.be[0] & (idx == REG_IRQ_CLEAR);
  assign kpc_be_o     = (wr_hit && (idx == REG_KERNEL_PC)) ? req_if.be : 4'b0000;
  assign wdata_o      = req_if.wdata;

  always_comb begin
    rvalid_d = req_if.req;
    rdata_d  = '0;
    if (rd_hit) begin
      case (idx)
        REG_ENABLE:    rdata_d = {31'b0, enable_i};
        REG_STATUS:    rdata_d = status_i;
        REG_KERNEL_PC: rdata_d = kernel_pc_i;
`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
        REG_CYCLE_CNT: rdata_d = cycle_cnt_i;
`endif
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rsp_if.rvalid = rvalid_q;
  assign rsp_if.rdata  = rdata_q;

endmodule

// File: rtl/gpu_conf_regs.sv
// GPU configuration registers: enable, kernel PC and the IDLE/RUNNING/DONE launch
// FSM behind an OBI slave. Define GPU_CONF_REGS_CYCLE_CNT_EN to add CYCLE_CNT.
module gpu_conf_regs
  import e_gpu_pkg::*;
#(
  parameter logic [31:0] KERNEL_PC_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  obi_req_if.slave    conf_regs_req,
  obi_rsp_if.slave    conf_regs_rsp,
  input  logic        done_i,
  output logic        enable_o,
  output logic        start_o,
  output logic [31:0] kernel_pc_o,
  output logic        interrupt_o
);

  conf_state_e state_q, state_d;
  logic        enable_q, enable_d;
  logic        start_q, start_d;
  logic [31:0] kpc_q, kpc_d;
  logic        enable_we, start_we, irq_clr_we;
  logic [3:0]  kpc_be;
  logic [31:0] wdata;
  logic [31:0] status;

  assign status = pack_status(state_q, enable_q, interrupt_o);

`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  gpu_conf_obi_slave u_obi_slave (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_if       (conf_regs_req),
    .rsp_if       (conf_regs_rsp),
    .enable_we_o  (enable_we),
    .start_we_o   (start_we),
    .irq_clr_we_o (irq_clr_we),
    .kpc_be_o     (kpc_be),
    .wdata_o      (wdata),
    .enable_i     (enable_q),
    .status_i     (status),
    .kernel_pc_i  (kpc_q)
`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
    ,
    .cycle_cnt_i  (cnt_q)
`endif
  );

  // Disabling overrides every state transition and any launch in progress
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    start_d  = 1'b0;
    if (enable_we) enable_d = wdata[0];
    if (enable_we && !wdata[0]) begin
      state_d = CONF_IDLE;
    end else begin
      unique case (state_q)
        CONF_IDLE: begin
          if (start_we && wdata[0] && enable_q) begin
            state_d = CONF_RUNNING;
            start_d = 1'b1;
          end
        end
        CONF_RUNNING: if (done_i) state_d = CONF_DONE;
        CONF_DONE:    if (irq_clr_we && wdata[0]) state_d = CONF_IDLE;
        default:      state_d = CONF_IDLE;
      endcase
    end
  end

  always_comb begin
    kpc_d = kpc_q;
    for (int b = 0; b < 4; b++) begin
      if (kpc_be[b]) kpc_d[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CONF_IDLE;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      kpc_q    <= KERNEL_PC_RST;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      start_q  <= start_d;
      kpc_q    <= kpc_d;
    end
  end

`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
  // Cleared on the launch edge, so the start_o cycle is the first counted one
  always_comb begin
    cnt_d = cnt_q;
    if (start_d) begin
      cnt_d = '0;
    end else if ((state_q == CONF_RUNNING) && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign enable_o    = enable_q;
  assign start_o     = start_q;
  assign kernel_pc_o = kpc_q;
  assign interrupt_o = (state_q == CONF_DONE);

endmodule

// File: tb/tb_gpu_conf_regs.sv
// Self-checking bench for gpu_conf_regs: directed scenarios, randomized bus and
// done_i traffic against a register-level reference model, and reset checks.
module tb_gpu_conf_regs;

  localparam logic [31:0] PC_RST = 32'h1000_0040;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        done;
  logic        enable_o, start_o, interrupt_o;
  logic [31:0] kernel_pc_o;

  obi_req_if req_bus ();
  obi_rsp_if rsp_bus ();

  gpu_conf_regs #(.KERNEL_PC_RST(PC_RST)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .conf_regs_req (req_bus),
    .conf_regs_rsp (rsp_bus),
    .done_i        (done),
    .enable_o      (enable_o),
    .start_o       (start_o),
    .kernel_pc_o   (kernel_pc_o),
    .interrupt_o   (interrupt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 running, 2 done
  int          m_state;
  bit          m_en;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] obs_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0;
    m_en    = 1'b0;
    m_pc    = PC_RST;
    m_cnt   = 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= 32'h20 || a[1:0] != 2'b00) return 32'h0;
    case (a[4:2])
      3'd0: return {31'b0, m_en};
      3'd3: return 32'(m_state) + (m_en ? 32'd4 : 32'd0) + ((m_state == 2) ? 32'd8 : 32'd0);
      3'd4: return m_pc;
`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
      3'd5: return m_cnt;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, predict, advance a clock, compare everything.
  task automatic step(input bit rq, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit dn);
    logic [31:0] exp_rd;
    bit          hit, ctl, pulse, nen;
    int          ns;
    logic [2:0]  idx;
    req_bus.req   = rq;
    req_bus.we    = wr;
    req_bus.addr  = a;
    req_bus.wdata = d;
    req_bus.be    = be;
    done          = dn;
    #1;
    check_eq("gnt", {31'b0, req_bus.gnt}, {31'b0, rq});
    exp_rd = (rq && !wr) ? model_read(a) : 32'h0;
    hit    = rq && wr && (a < 32'h20) && (a[1:0] == 2'b00);
    idx    = a[4:2];
    ctl    = hit && be[0] && d[0];
    pulse  = 1'b0;
    ns     = m_state;
    nen    = m_en;
    if (hit && be[0] && idx == 3'd0) nen = d[0];
    if (hit && be[0] && idx == 3'd0 && !d[0]) ns = 0;
    else if (m_state == 0 && ctl && idx == 3'd1 && m_en) begin ns = 1; pulse = 1'b1; end
    else if (m_state == 1 && dn) ns = 2;
    else if (m_state == 2 && ctl && idx == 3'd2) ns = 0;
    if (pulse) m_cnt = 32'h0;
    else if (m_state == 1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (hit && idx == 3'd4) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_pc[8*b +: 8] = d[8*b +: 8];
    end
    m_state = ns;
    m_en    = nen;
    @(posedge clk);
    #1;
    obs_rdata = rsp_bus.rdata;
    check_eq("rvalid", {31'b0, rsp_bus.rvalid}, {31'b0, rq});
    check_eq("rdata", rsp_bus.rdata, exp_rd);
    check_eq("start_o", {31'b0, start_o}, {31'b0, pulse});
    check_eq("enable_o", {31'b0, enable_o}, {31'b0, m_en});
    check_eq("interrupt_o", {31'b0, interrupt_o}, {31'b0, (m_state == 2)});
    check_eq("kernel_pc_o", kernel_pc_o, m_pc);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, 4'hF, 1'b0);
  endtask

  task automatic rd32(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0, 4'hF, 1'b0);
  endtask

  task automatic idle(input bit dn);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, dn);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_enable"}, {31'b0, enable_o}, 32'h0);
    check_eq({tag, "_start"}, {31'b0, start_o}, 32'h0);
    check_eq({tag, "_irq"}, {31'b0, interrupt_o}, 32'h0);
    check_eq({tag, "_gnt"}, {31'b0, req_bus.gnt}, 32'h0);
    check_eq({tag, "_rvalid"}, {31'b0, rsp_bus.rvalid}, 32'h0);
    check_eq({tag, "_rdata"}, rsp_bus.rdata, 32'h0);
    check_eq({tag, "_kpc"}, kernel_pc_o, PC_RST);
  endtask

  initial begin
    rst_ni        = 1'b0;
    done          = 1'b0;
    req_bus.req   = 1'b1;
    req_bus.we    = 1'b0;
    req_bus.be    = 4'hF;
    req_bus.addr  = 32'hC;
    req_bus.wdata = 32'h0;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    req_bus.req = 1'b0;
    rst_ni      = 1'b1;
    @(posedge clk);
    #1;

    rd32(32'hC);
    check_eq("status_after_reset", obs_rdata, 32'h0);

    // Launch
    wr32(32'h0, 32'h1);
    wr32(32'h10, 32'h8000_0000);
    wr32(32'h4, 32'h1);
    check_eq("launch_start", {31'b0, start_o}, 32'h1);
    rd32(32'hC);
    check_eq("launch_start_one_cycle", {31'b0, start_o}, 32'h0);
    check_eq("status_running", obs_rdata, 32'h5);
    check_eq("launch_kpc", kernel_pc_o, 32'h8000_0000);

    // Complete and clear
    idle(1'b1);
    check_eq("irq_after_done", {31'b0, interrupt_o}, 32'h1);
    rd32(32'hC);
    check_eq("status_done", obs_rdata, 32'hE);
    wr32(32'h8, 32'h1);
    check_eq("irq_cleared", {31'b0, interrupt_o}, 32'h0);
    rd32(32'hC);
    check_eq("status_idle_en", obs_rdata, 32'h4);

    // START while disabled, then done with IRQ_CLEAR in the same cycle
    wr32(32'h0, 32'h0);
    wr32(32'h4, 32'h1);
    check_eq("no_start_disabled", {31'b0, start_o}, 32'h0);
    rd32(32'hC);
    check_eq("status_disabled", obs_rdata, 32'h0);
    wr32(32'h0, 32'h1);
    wr32(32'h4, 32'h1);
    step(1'b1, 1'b1, 32'h8, 32'h1, 4'hF, 1'b1);
    rd32(32'hC);
    check_eq("status_done_clear_race", obs_rdata, 32'hE);
    wr32(32'h0, 32'h0);

    // Unmapped read and byte-enabled PC write
    rd32(32'h1C);
    check_eq("unmapped_rdata", obs_rdata, 32'h0);
    wr32(32'h10, 32'h0);
    step(1'b1, 1'b1, 32'h10, 32'hAAAA_BBBB, 4'b0011, 1'b0);
    check_eq("kpc_byte_enable", kernel_pc_o, 32'h0000_BBBB);

    // Cycle counter: 100 RUNNING cycles including the done cycle
    wr32(32'h0, 32'h1);
    wr32(32'h4, 32'h1);
    repeat (99) idle(1'b0);
    idle(1'b1);
    rd32(32'h14);
`ifdef GPU_CONF_REGS_CYCLE_CNT_EN
    check_eq("cycle_cnt_100", obs_rdata, 32'd100);
`else
    check_eq("cycle_cnt_unmapped", obs_rdata, 32'h0);
`endif
    wr32(32'h8, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      int          sel;
      sel = $urandom_range(0, 11);
      a   = (sel < 8) ? 32'(sel * 4) : ((sel < 10) ? 32'h4 : ((sel == 10) ? 32'h20 : 32'h2));
      d   = $urandom();
      if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      be  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, a, d, be,
           $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a read transaction
    wr32(32'h0, 32'h1);
    wr32(32'h10, 32'h1234_5678);
    wr32(32'h4, 32'h1);
    req_bus.req  = 1'b1;
    req_bus.we   = 1'b0;
    req_bus.addr = 32'hC;
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    req_bus.req = 1'b0;
    rst_ni      = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("no_rvalid_after_reset", {31'b0, rsp_bus.rvalid}, 32'h0);
    rd32(32'hC);
    check_eq("status_after_midreset", obs_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_conf_regs.md
GPU_CONF_REGS -- requirements
Module: gpu_conf_regs

Interface
REQ-001 SHALL have parameter KERNEL_PC_RST, default 32'h0000_0000, reset value of KERNEL_PC.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port conf_regs_req  obi_req_if slave  -  host access: req, we, be[3:0], addr[31:0], wdata[31:0] in; gnt out.
REQ-005 SHALL have port conf_regs_rsp  obi_rsp_if slave  -  rvalid, rdata[31:0] out.
REQ-006 SHALL have port done_i  input  1  kernel-complete pulse from GPU core.
REQ-007 SHALL have port enable_o  output  1  GPU core enable.
REQ-008 SHALL have port start_o  output  1  one-cycle kernel launch pulse.
REQ-009 SHALL have port kernel_pc_o  output  32  kernel entry address.
REQ-010 SHALL have port interrupt_o  output  1  level interrupt to host, high while in DONE.

Function
REQ-011 SHALL decode addr[4:2]: 0x00 ENABLE (RW, bit0), 0x04 START (WO, bit0), 0x08 IRQ_CLEAR (WO, bit0), 0x0C STATUS (RO), 0x10 KERNEL_PC (RW, 32 bits).
REQ-012 SHALL assert gnt combinationally in every cycle req=1 (no backpressure).
REQ-013 SHALL assert rvalid exactly one cycle after each granted request, reads and writes alike; rdata valid only with rvalid, 0 otherwise.
REQ-014 SHALL honour be per byte for KERNEL_PC; ENABLE/START/IRQ_CLEAR act only when be[0]=1.
REQ-015 SHALL ignore writes to unmapped or RO addresses and return 0 on reads of unmapped or WO addresses; rvalid still returned.
REQ-016 SHALL implement FSM IDLE(0), RUNNING(1), DONE(2).
REQ-017 IDLE: START write bit0=1 with ENABLE=1 -> start_o=1 the following cycle for exactly one cycle, state RUNNING; with ENABLE=0 the write is ignored.
REQ-018 RUNNING: done_i=1 -> DONE next cycle; START writes ignored.
REQ-019 DONE: interrupt_o=1; IRQ_CLEAR write bit0=1 -> IDLE, interrupt_o=0 next cycle; done_i ignored.
REQ-020 SHALL, on ENABLE write of 0 in any state, go to IDLE next cycle, deassert interrupt_o, suppress any pending start_o.
REQ-021 SHALL, on done_i and IRQ_CLEAR in the same RUNNING cycle, go to DONE (clear has no effect outside DONE).
REQ-022 STATUS SHALL read {28'b0, interrupt_o, enable_o, state[1:0]}.
REQ-023 KERNEL_PC writes SHALL take effect on kernel_pc_o the next cycle, in any state.

Reset
REQ-024 SHALL on rst_ni=0 asynchronously set: state IDLE, enable_o=0, start_o=0, interrupt_o=0, gnt=0, rvalid=0, rdata=0, kernel_pc_o=KERNEL_PC_RST.
REQ-025 SHALL drop any in-flight response on reset mid-transaction; no rvalid after release.

Configuration
REQ-026 SHALL, with GPU_CONF_REGS_CYCLE_CNT_EN defined, add RO register CYCLE_CNT at 0x14: 32-bit counter cleared on start_o, incremented each RUNNING cycle, frozen in DONE/IDLE, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL, without GPU_CONF_REGS_CYCLE_CNT_EN, have no counter logic and treat 0x14 as unmapped (reads 0).

Structure
REQ-028 SHALL take register offsets, FSM state enum (conf_state_e) and STATUS field positions from shared package e_gpu_pkg.
REQ-029 SHALL split as one sub-module gpu_conf_obi_slave (OBI handshake, decode, response register); FSM and registers in top.

Verification
REQ-030 Reset: hold rst_ni=0 10 cycles -> all outputs 0, kernel_pc_o=KERNEL_PC_RST, STATUS read after release = 0x0.
REQ-031 Launch: write 0x00=1, 0x10=0x8000_0000, 0x04=1 -> start_o high one cycle, STATUS=0x5, kernel_pc_o=0x8000_0000.
REQ-032 Complete: pulse done_i in RUNNING -> interrupt_o=1 next cycle, STATUS=0xE; write 0x08=1 -> interrupt_o=0, STATUS=0x4.
REQ-033 Corner: START with ENABLE=0 -> no start_o, STATUS=0x0; done_i with IRQ_CLEAR same cycle -> STATUS=0xE.
REQ-034 Bus: read 0x1C -> rvalid one cycle after gnt, rdata=0; write 0x10 be=4'b0011 data 0xAAAA_BBBB over 0 -> kernel_pc_o=0x0000_BBBB.
REQ-035 Counter (macro on): launch, done_i after 100 RUNNING cycles -> CYCLE_CNT read 100; macro off -> 0x14 reads 0.
